// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state codes, digit limits
// and two-digit BCD increment/decrement helpers.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_INICIAL    = 3'b000,
    ST_ESTABLECER = 3'b001,
    ST_CONTANDO   = 3'b010,
    ST_DETENIDO   = 3'b011,
    ST_FINAL      = 3'b101
  } state_t;

  localparam int unsigned MAX_MIN = 59;
  localparam int unsigned MAX_SEC = 59;

  // Each field holds two BCD digits: [7:4] tens, [3:0] units.
  typedef struct packed {
    logic [7:0] mins;
    logic [7:0] secs;
  } mmss_t;

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input int unsigned lim);
    logic [7:0] r;
    if (v == {4'(lim / 10), 4'(lim % 10)}) r = 8'h00;
    else if (v[3:0] == 4'd9)               r = {v[7:4] + 4'd1, 4'd0};
    else                                   r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input int unsigned lim);
    logic [7:0] r;
    if (v == 8'h00)          r = {4'(lim / 10), 4'(lim % 10)};
    else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                     r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r      = t;
    r.secs = bcd2_dec(t.secs, MAX_SEC);
    if (t.secs == 8'h00) r.mins = bcd2_dec(t.mins, MAX_MIN);
    return r;
  endfunction

  function automatic logic mmss_is_zero(input mmss_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/timer_if.sv
// Button and display bundle of the countdown timer; master drives the buttons,
// slave (timer_fsm) drives the BCD digits and status.
interface timer_if;
  logic       btn_set;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic       inc_min;
  logic       inc_sec;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [2:0] actualState;
  logic       finish;
  logic       clk1Hz;

  modport master (
    output btn_set, btn_start, btn_stop, btn_clear, inc_min, inc_sec,
    input  dig0, dig1, dig2, dig3, actualState, finish, clk1Hz
  );

  modport slave (
    input  btn_set, btn_start, btn_stop, btn_clear, inc_min, inc_sec,
    output dig0, dig1, dig2, dig3, actualState, finish, clk1Hz
  );
endinterface

// File: rtl/timer_sec_tick_gen.sv
// One-second divider: counts 0..CLK_HZ-1, flags the wrap cycle as tick and
// derives a 50 % duty 1 Hz square wave from the same count.
module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic clk1Hz
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_clk1hz;

  always_comb begin
    w_count_next = r_count + CW'(1);
    if (restart || (r_count == LAST)) w_count_next = '0;
  end

  // The square wave is registered from the next count so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_clk1hz <= 1'b1;
    end else begin
      r_count  <= w_count_next;
      r_clk1hz <= (w_count_next < HALF);
    end
  end

  assign tick   = (r_count == LAST);
  assign clk1Hz = r_clk1hz;
endmodule

// File: rtl/timer_fsm.sv
// MM:SS countdown timer state machine with BCD time registers.
// Optional macro TIMER_FINAL_TIMEOUT_EN: leave FINAL after FINAL_HOLD_S ticks.
module timer_fsm
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int FINAL_HOLD_S = 10
) (
  input  logic    clk,
  input  logic    reset,
  timer_if.slave  bus
);
  state_t r_state;
  state_t w_state_next;
  mmss_t  r_time;
  mmss_t  w_time_next;
  logic   r_finish;
  logic   w_tick;
  logic   w_restart;
  logic   w_clk1hz;
  logic   w_timeout;

  if (CLK_HZ < 2 || FINAL_HOLD_S < 1) begin : g_bad_param
    $error("timer_fsm: CLK_HZ must be >= 2 and FINAL_HOLD_S >= 1");
  end

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .tick    (w_tick),
    .clk1Hz  (w_clk1hz)
  );

`ifdef TIMER_FINAL_TIMEOUT_EN
  localparam int HOLD_W = $clog2(FINAL_HOLD_S + 1);
  logic [HOLD_W-1:0] r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_hold <= '0;
    else if (r_state != ST_FINAL) r_hold <= '0;
    else if (w_tick)              r_hold <= r_hold + HOLD_W'(1);
  end

  assign w_timeout = (r_state == ST_FINAL) && w_tick &&
                     (r_hold == HOLD_W'(FINAL_HOLD_S - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_time_next  = r_time;
    if (bus.btn_clear && (r_state != ST_INICIAL)) begin
      w_state_next = ST_INICIAL;
      w_time_next  = '0;
    end else begin
      case (r_state)
        ST_INICIAL: begin
          if (bus.btn_set) w_state_next = ST_ESTABLECER;
        end
        ST_ESTABLECER: begin
          if (bus.inc_min) w_time_next.mins = bcd2_inc(r_time.mins, MAX_MIN);
          if (bus.inc_sec) w_time_next.secs = bcd2_inc(r_time.secs, MAX_SEC);
          if (bus.btn_start && !mmss_is_zero(r_time)) w_state_next = ST_CONTANDO;
        end
        ST_CONTANDO: begin
          // A tick is applied before a simultaneous stop; reaching zero beats stop.
          if (w_tick) begin
            w_time_next = mmss_dec(r_time);
            if (mmss_is_zero(w_time_next)) w_state_next = ST_FINAL;
            else if (bus.btn_stop)         w_state_next = ST_DETENIDO;
          end else if (bus.btn_stop) begin
            w_state_next = ST_DETENIDO;
          end
        end
        ST_DETENIDO: begin
          if (bus.btn_start) w_state_next = ST_CONTANDO;
        end
        ST_FINAL: begin
          w_time_next = '0;
          if (w_timeout) w_state_next = ST_INICIAL;
        end
        default: begin
          w_state_next = ST_INICIAL;
          w_time_next  = '0;
        end
      endcase
    end
  end

  assign w_restart = (w_state_next == ST_CONTANDO) && (r_state != ST_CONTANDO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_INICIAL;
      r_time   <= '0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_time   <= w_time_next;
      r_finish <= (w_state_next == ST_FINAL);
    end
  end

  assign bus.dig0        = r_time.mins[7:4];
  assign bus.dig1        = r_time.mins[3:0];
  assign bus.dig2        = r_time.secs[7:4];
  assign bus.dig3        = r_time.secs[3:0];
  assign bus.actualState = r_state;
  assign bus.finish      = r_finish;
  assign bus.clk1Hz      = w_clk1hz;
endmodule

// File: tb/tb_timer_fsm.sv
// Self-checking bench for timer_fsm: vector table, directed corner sequences
// and random stimulus against a total-seconds reference model.
module tb_timer_fsm;
  localparam int CLK_HZ = 10;
  localparam int HOLD_S = 3;

  localparam logic [2:0] S_INI = 3'b000;
  localparam logic [2:0] S_EST = 3'b001;
  localparam logic [2:0] S_CNT = 3'b010;
  localparam logic [2:0] S_DET = 3'b011;
  localparam logic [2:0] S_FIN = 3'b101;

  typedef struct packed {
    logic set;
    logic start;
    logic stop;
    logic clear;
    logic imin;
    logic isec;
  } btn_t;

  localparam btn_t B_NONE  = 6'b000000;
  localparam btn_t B_SET   = 6'b100000;
  localparam btn_t B_START = 6'b010000;
  localparam btn_t B_STOP  = 6'b001000;
  localparam btn_t B_CLEAR = 6'b000100;
  localparam btn_t B_IMIN  = 6'b000010;
  localparam btn_t B_ISEC  = 6'b000001;

  typedef struct {
    btn_t        b;
    logic [2:0]  st;
    logic [15:0] digs;
    logic        fin;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timer_if bus ();

  timer_fsm #(.CLK_HZ(CLK_HZ), .FINAL_HOLD_S(HOLD_S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] m_state;
  int         m_min;
  int         m_sec;
  int         m_div;
`ifdef TIMER_FINAL_TIMEOUT_EN
  int         m_hold;
`endif

  vec_t tbl[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [20:0] dut_word();
    return {bus.actualState, bus.dig0, bus.dig1, bus.dig2, bus.dig3, bus.finish, bus.clk1Hz};
  endfunction

  function automatic logic [15:0] dut_digs();
    return {bus.dig0, bus.dig1, bus.dig2, bus.dig3};
  endfunction

  function automatic logic [20:0] model_word();
    logic [15:0] d;
    d = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    return {m_state, d, (m_state == S_FIN), (m_div < CLK_HZ / 2)};
  endfunction

  function automatic void model_reset();
    m_state = S_INI;
    m_min   = 0;
    m_sec   = 0;
    m_div   = 0;
  endfunction

  // Time kept as plain minutes/seconds; countdown works on the total in seconds.
  function automatic void model_step(input btn_t b);
    bit tick;
    bit enter;
    int total;
    tick  = (m_div == CLK_HZ - 1);
    enter = 0;
    total = m_min * 60 + m_sec;
    if (b.clear && m_state != S_INI) begin
      m_state = S_INI;
      m_min   = 0;
      m_sec   = 0;
    end else begin
      case (m_state)
        S_INI: if (b.set) m_state = S_EST;
        S_EST: begin
          if (b.imin) m_min = (m_min + 1) % 60;
          if (b.isec) m_sec = (m_sec + 1) % 60;
          if (b.start && total != 0) begin
            m_state = S_CNT;
            enter   = 1;
          end
        end
        S_CNT: begin
          if (tick) begin
            total = total - 1;
            m_min = total / 60;
            m_sec = total % 60;
          end
          if (tick && total == 0) begin
            m_state = S_FIN;
`ifdef TIMER_FINAL_TIMEOUT_EN
            m_hold  = 0;
`endif
          end else if (b.stop) begin
            m_state = S_DET;
          end
        end
        S_DET: if (b.start) begin
          m_state = S_CNT;
          enter   = 1;
        end
        S_FIN: begin
`ifdef TIMER_FINAL_TIMEOUT_EN
          if (tick) begin
            m_hold = m_hold + 1;
            if (m_hold == HOLD_S) m_state = S_INI;
          end
`endif
        end
        default: m_state = S_INI;
      endcase
    end
    m_div = enter ? 0 : (m_div + 1) % CLK_HZ;
  endfunction

  task automatic drive(input btn_t b);
    bus.btn_set   = b.set;
    bus.btn_start = b.start;
    bus.btn_stop  = b.stop;
    bus.btn_clear = b.clear;
    bus.inc_min   = b.imin;
    bus.inc_sec   = b.isec;
  endtask

  task automatic cycle(input btn_t b);
    drive(b);
    @(posedge clk);
    model_step(b);
    #1;
    check("step", 32'(dut_word()), 32'(model_word()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(B_NONE);
  endtask

  task automatic set_time(input int mins, input int secs);
    cycle(B_SET);
    for (int k = 0; k < mins; k++) cycle(B_IMIN);
    for (int k = 0; k < secs; k++) cycle(B_ISEC);
  endtask

  function automatic void add(input btn_t b, input logic [2:0] st, input logic [15:0] d, input logic f);
    vec_t v;
    v.b    = b;
    v.st   = st;
    v.digs = d;
    v.fin  = f;
    tbl.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(B_NONE);
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("reset_outputs", 32'(dut_word()), 32'({S_INI, 16'h0000, 1'b0, 1'b1}));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Set 02:05, start, first decrement after CLK_HZ cycles, then pause/resume/clear.
    add(B_START | B_STOP | B_IMIN | B_ISEC | B_CLEAR, S_INI, 16'h0000, 1'b0);
    add(B_SET,  S_EST, 16'h0000, 1'b0);
    add(B_IMIN, S_EST, 16'h0100, 1'b0);
    add(B_IMIN, S_EST, 16'h0200, 1'b0);
    for (int k = 1; k <= 5; k++) add(B_ISEC, S_EST, 16'h0200 + 16'(k), 1'b0);
    add(B_START, S_CNT, 16'h0205, 1'b0);
    for (int k = 0; k < 9; k++) add(B_NONE, S_CNT, 16'h0205, 1'b0);
    add(B_NONE,  S_CNT, 16'h0204, 1'b0);
    add(B_STOP,  S_DET, 16'h0204, 1'b0);
    for (int k = 0; k < 12; k++) add(B_NONE, S_DET, 16'h0204, 1'b0);
    add(B_START, S_CNT, 16'h0204, 1'b0);
    add(B_STOP,  S_DET, 16'h0204, 1'b0);
    add(B_CLEAR, S_INI, 16'h0000, 1'b0);

    foreach (tbl[i]) begin
      cycle(tbl[i].b);
      check($sformatf("tbl%0d", i), 32'({bus.actualState, dut_digs(), bus.finish}),
            32'({tbl[i].st, tbl[i].digs, tbl[i].fin}));
    end

    // Borrow from minutes, then terminal tick into FINAL.
    set_time(1, 0);
    cycle(B_START);
    idle(9);
    check("pre_borrow", 32'(dut_digs()), 32'h0100);
    idle(1);
    check("borrow", 32'(dut_digs()), 32'h0059);
    check("borrow_state", 32'(bus.actualState), 32'(S_CNT));
    cycle(B_CLEAR);
    set_time(0, 1);
    cycle(B_START);
    idle(9);
    check("pre_final", 32'({bus.actualState, bus.finish}), 32'({S_CNT, 1'b0}));
    idle(1);
    check("final_state", 32'(bus.actualState), 32'(S_FIN));
    check("final_finish", 32'(bus.finish), 32'd1);
    check("final_digs", 32'(dut_digs()), 32'h0000);
`ifdef TIMER_FINAL_TIMEOUT_EN
    idle(29);
    check("hold_pre", 32'({bus.actualState, bus.finish}), 32'({S_FIN, 1'b1}));
    idle(1);
    check("hold_exit", 32'({bus.actualState, bus.finish}), 32'({S_INI, 1'b0}));
`else
    idle(100);
    check("hold_stay", 32'({bus.actualState, bus.finish}), 32'({S_FIN, 1'b1}));
`endif
    cycle(B_CLEAR);
    check("after_final", 32'(bus.actualState), 32'(S_INI));

    // Stop coinciding with terminal and non-terminal ticks.
    set_time(0, 1);
    cycle(B_START);
    idle(9);
    cycle(B_STOP);
    check("stop_terminal", 32'(bus.actualState), 32'(S_FIN));
    cycle(B_CLEAR);
    set_time(0, 10);
    cycle(B_START);
    idle(9);
    cycle(B_STOP);
    check("stop_tick", 32'({bus.actualState, dut_digs()}), 32'({S_DET, 16'h0009}));
    idle(12);
    check("paused", 32'({bus.actualState, dut_digs()}), 32'({S_DET, 16'h0009}));
    cycle(B_CLEAR);

    // Increment wrap, start refused at 00:00, both increments at once.
    cycle(B_SET);
    for (int k = 0; k < 60; k++) cycle(B_ISEC);
    check("sec_wrap", 32'(dut_digs()), 32'h0000);
    cycle(B_START);
    check("start_zero", 32'(bus.actualState), 32'(S_EST));
    for (int k = 0; k < 60; k++) cycle(B_IMIN);
    check("min_wrap", 32'(dut_digs()), 32'h0000);
    cycle(B_IMIN | B_ISEC);
    check("both_inc", 32'(dut_digs()), 32'h0101);
    cycle(B_CLEAR);
    check("clear_est", 32'({bus.actualState, dut_digs()}), 32'({S_INI, 16'h0000}));

    // Asynchronous reset in the middle of a countdown.
    set_time(0, 30);
    cycle(B_START);
    idle(7);
    check("pre_reset", 32'({bus.actualState, dut_digs(), bus.clk1Hz}), 32'({S_CNT, 16'h0030, 1'b0}));
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", 32'(dut_word()), 32'({S_INI, 16'h0000, 1'b0, 1'b1}));
    @(negedge clk);
    reset = 1'b0;
    cycle(B_START | B_STOP | B_ISEC);
    idle(14);
    check("post_reset", 32'({bus.actualState, dut_digs()}), 32'({S_INI, 16'h0000}));

    // Random pulses against the reference model.
    cycle(B_CLEAR);
    for (int i = 0; i < 4000; i++) begin
      btn_t b;
      b.set   = ($urandom_range(0, 7) == 0);
      b.start = ($urandom_range(0, 5) == 0);
      b.stop  = ($urandom_range(0, 15) == 0);
      b.clear = ($urandom_range(0, 199) == 0);
      b.imin  = ($urandom_range(0, 31) == 0);
      b.isec  = ($urandom_range(0, 2) == 0);
      cycle(b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
